// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and sizing helpers for the UART receiver and echo transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   function automatic int half_bit(input int div);
      return div / 2;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_echo.sv
// rtl/uart_tx_echo.sv - echo transmitter: sends one loaded word as start, data LSB first, optional even parity, stop
module uart_tx_echo
   import uart_pkg::*;
#(
   parameter int N       = 8,
   parameter int PSCALER = 1,
   parameter int DIV     = 10
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         parity_en,
   input  logic [N-1:0] data,
   output logic         tx
);

   localparam int PW = cnt_width(PSCALER);
   localparam int TW = cnt_width(DIV);
   localparam int BW = cnt_width(N);
   localparam logic [PW-1:0] P_LAST = PW'(PSCALER - 1);
   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(N - 1);

   uart_state_t   state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [BW-1:0] bcnt;
   logic [N-1:0]  shreg;
   logic          par;
   logic          pen;
   logic          bit_end;

   assign bit_end = (pcnt == P_LAST) && (tcnt == T_LAST);

   // start is ignored while busy, so a word arriving mid-transmission is dropped
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         pcnt  <= '0;
         tcnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
         par   <= 1'b0;
         pen   <= 1'b0;
         tx    <= 1'b1;
      end else begin
         if (state == ST_IDLE) begin
            pcnt <= '0;
            tcnt <= '0;
         end else if (pcnt == P_LAST) begin
            pcnt <= '0;
            tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  shreg <= data;
                  par   <= ^data;
                  pen   <= parity_en;
                  bcnt  <= '0;
                  tx    <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bcnt == B_LAST) begin
                     tx    <= pen ? par : 1'b1;
                     state <= pen ? ST_PARITY : ST_STOP;
                  end else begin
                     bcnt  <= bcnt + 1'b1;
                     tx    <= shreg[0];
                     shreg <= shreg >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with optional even parity, error flags and an echo port
module uart_rx
   import uart_pkg::*;
#(
   parameter int N       = 8,
   parameter int PSCALER = 1,
   parameter int DIV     = 10
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic         parity_i,
   input  logic         rx_i,
   output logic         tx_o,
   output logic [N-1:0] data_o,
   output logic         valid_o,
   output logic         parity_err_o,
   output logic         frame_err_o
);

   localparam int HALF_BIT = half_bit(DIV);
   localparam int PW = cnt_width(PSCALER);
   localparam int TW = cnt_width(DIV);
   localparam int BW = cnt_width(N);
   localparam logic [PW-1:0] P_LAST = PW'(PSCALER - 1);
   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(N - 1);

   uart_state_t   state;
   logic          sync1;
   logic          rx_s;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [BW-1:0] bcnt;
   logic [N-1:0]  shreg;
   logic          par_en;
   logic          par_err;
   logic          armed;
   logic          tick;

   assign tick = (pcnt == P_LAST);

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx_i;
         rx_s  <= sync1;
      end
   end

   // armed drops after a low stop bit so the still-low line is not taken as a new start
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         pcnt         <= '0;
         tcnt         <= '0;
         bcnt         <= '0;
         shreg        <= '0;
         par_en       <= 1'b0;
         par_err      <= 1'b0;
         armed        <= 1'b1;
         data_o       <= '0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (state == ST_IDLE) pcnt <= '0;
         else pcnt <= tick ? '0 : pcnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (!armed) begin
                  armed <= rx_s;
               end else if (!rx_s) begin
                  par_en  <= parity_i;
                  par_err <= 1'b0;
                  tcnt    <= '0;
                  bcnt    <= '0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tcnt == T_HALF) begin
                     tcnt  <= '0;
                     state <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt  <= '0;
                     shreg <= {rx_s, shreg[N-1:1]};
                     if (bcnt == B_LAST) state <= par_en ? ST_PARITY : ST_STOP;
                     else bcnt <= bcnt + 1'b1;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt    <= '0;
                     par_err <= (^shreg) ^ rx_s;
                     state   <= ST_STOP;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt         <= '0;
                     data_o       <= shreg;
                     parity_err_o <= par_err;
                     frame_err_o  <= ~rx_s;
                     valid_o      <= 1'b1;
                     armed        <= rx_s;
                     state        <= ST_IDLE;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_echo #(
      .N       (N),
      .PSCALER (PSCALER),
      .DIV     (DIV)
   ) u_tx_echo (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .start     (valid_o & ~parity_err_o & ~frame_err_o),
      .parity_en (par_en),
      .data      (data_o),
      .tx        (tx_o)
   );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx and its echo transmitter
module tb_uart_rx;

   localparam int N       = 8;
   localparam int PSCALER = 1;
   localparam int DIV     = 10;
   localparam int BIT     = PSCALER * DIV;

   logic         sysclk   = 1'b0;
   logic         reset_n  = 1'b0;
   logic         parity_i = 1'b0;
   logic         rx_i     = 1'b1;
   logic         tx_o;
   logic [N-1:0] data_o;
   logic         valid_o;
   logic         parity_err_o;
   logic         frame_err_o;

   typedef struct {
      logic [N-1:0] data;
      logic         perr;
      logic         ferr;
      int           lat;
   } rx_exp_t;

   typedef struct {
      logic [N-1:0] data;
      logic         par;
   } tx_exp_t;

   rx_exp_t      rx_q[$];
   tx_exp_t      tx_q[$];
   rx_exp_t      re;
   tx_exp_t      te;
   logic [N-1:0] w;
   logic         tx_prev = 1'b1;
   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           edge_cyc = 0;
   int           valid_cnt = 0;
   int           lat;
   int           vc_before;

   uart_rx #(
      .N       (N),
      .PSCALER (PSCALER),
      .DIV     (DIV)
   ) dut (
      .sysclk       (sysclk),
      .reset_n      (reset_n),
      .parity_i     (parity_i),
      .rx_i         (rx_i),
      .tx_o         (tx_o),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .parity_err_o (parity_err_o),
      .frame_err_o  (frame_err_o)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (BIT) @(posedge sysclk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic send_frame(input logic [N-1:0] d, input logic pen, input logic good_par,
                             input logic stop, input logic flip);
      rx_exp_t e;
      tx_exp_t t;
      e.data = d;
      e.perr = pen & ~good_par;
      e.ferr = ~stop;
      e.lat  = (N + 1 + (pen ? 1 : 0)) * BIT + BIT / 2 + 3;
      rx_q.push_back(e);
      if (!e.perr && !e.ferr) begin
         t.data = d;
         t.par  = pen;
         tx_q.push_back(t);
      end
      parity_i = pen;
      @(posedge sysclk);
      #1;
      edge_cyc = cyc;
      drive_bit(1'b0);
      if (flip) parity_i = ~pen;
      for (int i = 0; i < N; i++) drive_bit(d[i]);
      if (pen) drive_bit(good_par ? ^d : ~(^d));
      drive_bit(stop);
      rx_i     = 1'b1;
      parity_i = pen;
   endtask

   initial begin
      forever begin
         @(negedge sysclk);
         if (valid_o === 1'b1) begin
            valid_cnt++;
            lat = cyc - edge_cyc;
            if (rx_q.size() == 0) begin
               check("valid_spurious", valid_o, 0);
            end else begin
               re = rx_q.pop_front();
               check("rx_data", data_o, re.data);
               check("rx_parity_err", parity_err_o, re.perr);
               check("rx_frame_err", frame_err_o, re.ferr);
               n_checks++;
               assert (lat >= re.lat - 1 && lat <= re.lat + 1) else begin
                  n_fail++;
                  $error("FAIL rx_latency: observed %0d expected %0d+-1", lat, re.lat);
               end
               @(negedge sysclk);
               check("valid_one_clock", valid_o, 0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge sysclk);
         if (reset_n && tx_prev && !tx_o) begin
            if (tx_q.size() == 0) begin
               check("echo_spurious", tx_o, 1);
            end else begin
               te = tx_q.pop_front();
               repeat (BIT / 2 - 1) @(negedge sysclk);
               check("echo_start", tx_o, 0);
               for (int i = 0; i < N; i++) begin
                  repeat (BIT) @(negedge sysclk);
                  w[i] = tx_o;
               end
               if (te.par) begin
                  repeat (BIT) @(negedge sysclk);
                  check("echo_parity", tx_o, ^te.data);
               end
               repeat (BIT) @(negedge sysclk);
               check("echo_stop", tx_o, 1);
               check("echo_data", w, te.data);
            end
         end
         tx_prev = tx_o;
      end
   end

   initial begin
      reset_n  = 1'b0;
      rx_i     = 1'b1;
      parity_i = 1'b0;
      repeat (5) @(posedge sysclk);
      #1;
      check("reset_tx", tx_o, 1);
      check("reset_valid", valid_o, 0);
      check("reset_data", data_o, 0);
      check("reset_perr", parity_err_o, 0);
      check("reset_ferr", frame_err_o, 0);
      reset_n = 1'b1;
      idle(20);
      check("idle_tx", tx_o, 1);
      check("idle_valid", valid_o, 0);
      check("idle_data", data_o, 0);

      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(130);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(130);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(130);
      send_frame(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(130);
      check("ferr_line_idle", tx_o, 1);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(130);

      vc_before = valid_cnt;
      @(posedge sysclk);
      #1;
      rx_i = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      idle(30);
      check("glitch_no_valid", valid_cnt, vc_before);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(130);

      vc_before = valid_cnt;
      parity_i = 1'b0;
      @(posedge sysclk);
      #1;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx_i = 1'b0;
      repeat (3) @(posedge sysclk);
      #3;
      reset_n = 1'b0;
      #1;
      check("abort_tx", tx_o, 1);
      check("abort_valid", valid_o, 0);
      check("abort_data", data_o, 0);
      repeat (3) @(posedge sysclk);
      #1;
      rx_i = 1'b1;
      reset_n = 1'b1;
      idle(30);
      check("abort_no_valid", valid_cnt, vc_before);
      send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(150);

      check("rx_queue_drained", rx_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
